// File: rtl/recon_pkg.sv
// Shared constants for the L6 reconstruction-chain scheduler.
package recon_pkg;

  localparam int DATA_W_DEF = 48;
  localparam int LEN_W_DEF  = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Value fed into the filter history during the flush slots.
  localparam int FLUSH_SAMPLE = 0;

endpackage

// File: rtl/recon_slot_timer.sv
// Issue-slot phase counter: wraps every PERIOD cycles, strobes at phase 0.
module recon_slot_timer #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic hold_i,
  output logic slot_o
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clear_i) begin
      phase_d = '0;
    end else if (!hold_i) begin
      phase_d = (phase_q == PW'(PERIOD - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign slot_o = (phase_q == '0);

endmodule

// File: rtl/recon_chain_sched.sv
// L6 frame scheduler: soft-clears the datapath, issues r6 samples at a fixed
// slot cadence, flushes the filter history, then counts chain outputs.
//
// state   | meaning
// IDLE    | waiting for start
// CLR     | datapath soft reset held low
// RUN     | issuing frame samples, one per slot
// FLUSH   | issuing zero samples to empty the filter history
// DRAIN   | counting remaining chain outputs, bounded by TIMEOUT
module recon_chain_sched
  import recon_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int PERIOD     = 4,
  parameter int FLUSH_TAPS = 3,
  parameter int OUT_RATIO  = 2,
  parameter int CLR_CYC    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              dp_rst_n,
  output logic              dp_valid,
  output logic [DATA_W-1:0] dp_data,
  input  logic              dp_out_valid,
  output logic              busy,
  output logic              done,
  output logic              err_underrun,
  output logic              err_timeout
);

  localparam int CW = LEN_W + 3;
  localparam int FW = $clog2(FLUSH_TAPS + 1);
  localparam int KW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic [KW-1:0]     clr_q, clr_d;
  logic [TW-1:0]     drain_q, drain_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     expected;
  logic              dp_valid_q, dp_valid_d;
  logic [DATA_W-1:0] dp_data_q, dp_data_d;
  logic              done_q, done_d;
  logic              err_u_q, err_u_d;
  logic              err_t_q, err_t_d;
  logic              slot, tmr_clear, tmr_hold, hs, count_en;

  recon_slot_timer #(.PERIOD(PERIOD)) u_slot_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (tmr_clear),
    .hold_i  (tmr_hold),
    .slot_o  (slot)
  );

  assign expected  = (CW'(len_q) + CW'(FLUSH_TAPS)) * CW'(OUT_RATIO);
  assign s_ready   = (state_q == S_RUN) && slot && (issued_q < len_q);
  assign hs        = s_ready && s_valid;
  assign tmr_clear = (state_q != S_RUN) && (state_q != S_FLUSH);
  assign tmr_hold  = s_ready && !s_valid;
  assign count_en  = (state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_DRAIN);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    flush_d    = flush_q;
    clr_d      = clr_q;
    drain_d    = '0;
    out_d      = out_q;
    dp_valid_d = 1'b0;
    dp_data_d  = dp_data_q;
    done_d     = 1'b0;
    err_u_d    = err_u_q;
    err_t_d    = err_t_q;

    if (count_en && dp_out_valid && (out_q != {CW{1'b1}})) out_d = out_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_CLR;
            len_d    = frame_len;
            issued_d = '0;
            flush_d  = '0;
            out_d    = '0;
            clr_d    = KW'(CLR_CYC - 1);
            err_u_d  = 1'b0;
            err_t_d  = 1'b0;
          end
        end
      end
      S_CLR: begin
        if (clr_q == '0) state_d = S_RUN;
        else             clr_d   = clr_q - 1'b1;
      end
      S_RUN: begin
        if (hs) begin
          dp_valid_d = 1'b1;
          dp_data_d  = s_data;
          issued_d   = issued_q + 1'b1;
          // The flush cadence continues from the same slot timer.
          if (issued_d == len_q) state_d = S_FLUSH;
        end else if (tmr_hold) begin
          err_u_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (slot) begin
          dp_valid_d = 1'b1;
          dp_data_d  = DATA_W'(FLUSH_SAMPLE);
          flush_d    = flush_q + 1'b1;
          if (flush_d == FW'(FLUSH_TAPS)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (out_q >= expected) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (drain_q == TW'(TIMEOUT - 1)) begin
          err_t_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      flush_q    <= '0;
      clr_q      <= '0;
      drain_q    <= '0;
      out_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_data_q  <= '0;
      done_q     <= 1'b0;
      err_u_q    <= 1'b0;
      err_t_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      flush_q    <= flush_d;
      clr_q      <= clr_d;
      drain_q    <= drain_d;
      out_q      <= out_d;
      dp_valid_q <= dp_valid_d;
      dp_data_q  <= dp_data_d;
      done_q     <= done_d;
      err_u_q    <= err_u_d;
      err_t_q    <= err_t_d;
    end
  end

  assign dp_rst_n     = (state_q != S_CLR);
  assign busy         = (state_q != S_IDLE);
  assign dp_valid     = dp_valid_q;
  assign dp_data      = dp_data_q;
  assign done         = done_q;
  assign err_underrun = err_u_q;
  assign err_timeout  = err_t_q;

endmodule

// File: tb/tb_recon_chain_sched.sv
// Directed bench for recon_chain_sched with a scoreboard of issued samples.
module tb_recon_chain_sched;

  localparam int DW = 48;
  localparam int LW = 16;
  localparam int PER = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          dp_rst_n;
  logic          dp_valid;
  logic [DW-1:0] dp_data;
  logic          dp_out_valid;
  logic          busy;
  logic          done;
  logic          err_underrun;
  logic          err_timeout;

  always #5 clk = ~clk;

  recon_chain_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .frame_len    (frame_len),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .dp_rst_n     (dp_rst_n),
    .dp_valid     (dp_valid),
    .dp_data      (dp_data),
    .dp_out_valid (dp_out_valid),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun),
    .err_timeout  (err_timeout)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] sb[$];
  int cyc_n = 0;
  int len_m, issued_m;
  int pulses, last_pulse, gaps_ne, gaps_short;
  int rstlow, done_cnt, done_cyc, busy_cnt;
  logic busy_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_reset(input int len);
    sb.delete();
    len_m = len; issued_m = 0;
    pulses = 0; last_pulse = -1; gaps_ne = 0; gaps_short = 0;
    rstlow = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
  endtask

  // One clock: record a handshake before the edge, observe outputs after it.
  task automatic cyc();
    logic          hs;
    logic [DW-1:0] d;
    hs = s_ready && s_valid;
    d  = s_data;
    if (hs) begin
      sb.push_back(d);
      issued_m++;
      if (issued_m == len_m) repeat (3) sb.push_back('0);
    end
    busy_prev = busy;
    @(posedge clk); #1;
    cyc_n++;
    if (hs) s_data = {16'($urandom), $urandom};
    if (dp_valid) begin
      if (sb.size() == 0) chk("dp_valid_unexpected", 64'd1, 64'd0);
      else chk("dp_data", 64'(dp_data), 64'(sb.pop_front()));
      if (last_pulse >= 0) begin
        if (cyc_n - last_pulse != PER) gaps_ne++;
        if (cyc_n - last_pulse < PER) gaps_short++;
      end
      pulses++;
      last_pulse = cyc_n;
    end
    if (!dp_rst_n) rstlow++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc_n; end
  endtask

  task automatic start_frame(input int len);
    frame_reset(len);
    start = 1'b1; frame_len = LW'(len);
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n);
    int k = 0;
    while (pulses < n && k < 200) begin cyc(); k++; end
    chk(tag, 64'(pulses), 64'(n));
  endtask

  task automatic feed(input int n);
    dp_out_valid = 1'b1;
    repeat (n) cyc();
    dp_out_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < maxc) begin cyc(); k++; end
    chk({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_busy_before_done"}, 64'(busy_prev), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, 64'({s_ready, dp_rst_n, dp_valid, busy, done, err_underrun, err_timeout}), 64'h20);
    chk({tag, "_data"}, 64'(dp_data), 64'd0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; frame_len = '0; s_valid = 1'b0;
    s_data = {16'($urandom), $urandom}; dp_out_valid = 1'b0;
    frame_reset(0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) cyc();

    // 1: nominal frame of 5
    s_valid = 1'b1;
    start_frame(5);
    wait_pulses("t1_pulses", 8);
    chk("t1_rstlow", 64'(rstlow), 64'd2);
    chk("t1_gaps", 64'(gaps_ne), 64'd0);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    feed(16);
    wait_done("t1", 20);
    chk("t1_errs", 64'({err_underrun, err_timeout}), 64'd0);
    repeat (3) cyc();
    chk("t1_single_done", 64'(done_cnt), 64'd1);

    // 2: underrun at the second slot
    start_frame(4);
    wait_pulses("t2_first", 1);
    s_valid = 1'b0;
    repeat (8) cyc();
    chk("t2_no_pulse_in_gap", 64'(pulses), 64'd1);
    chk("t2_underrun", 64'(err_underrun), 64'd1);
    s_valid = 1'b1;
    cyc();
    chk("t2_resume", 64'(pulses), 64'd2);
    wait_pulses("t2_pulses", 7);
    chk("t2_gaps_short", 64'(gaps_short), 64'd0);
    chk("t2_gaps_stretched", 64'(gaps_ne), 64'd1);
    feed(14);
    wait_done("t2", 20);
    chk("t2_errs", 64'({err_underrun, err_timeout}), 64'b10);

    // 3: drain timeout
    start_frame(2);
    wait_pulses("t3_pulses", 5);
    d0 = cyc_n;
    feed(5);
    wait_done("t3", 80);
    chk("t3_timeout_cycle", 64'(done_cyc - d0), 64'd64);
    chk("t3_errs", 64'({err_underrun, err_timeout}), 64'b01);

    // 4: zero-length frame
    start_frame(0);
    chk("t4_done_next", 64'(done), 64'd1);
    repeat (5) cyc();
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);
    chk("t4_quiet", 64'({pulses[7:0], rstlow[7:0], busy_cnt[7:0]}), 64'd0);
    chk("t4_err_kept", 64'(err_timeout), 64'd1);

    // 5: start mid-RUN ignored; outputs in IDLE and CLR not counted
    dp_out_valid = 1'b1;
    repeat (3) cyc();
    dp_out_valid = 1'b0;
    start_frame(3);
    dp_out_valid = 1'b1;
    repeat (2) cyc();
    dp_out_valid = 1'b0;
    chk("t5_clr_len", 64'(rstlow), 64'd2);
    wait_pulses("t5_first", 1);
    start = 1'b1; frame_len = 16'd7;
    cyc();
    start = 1'b0;
    wait_pulses("t5_pulses", 6);
    repeat (8) cyc();
    chk("t5_no_extra", 64'(pulses), 64'd6);
    chk("t5_gaps", 64'(gaps_ne), 64'd0);
    feed(11);
    repeat (4) cyc();
    chk("t5_not_early", 64'(done_cnt), 64'd0);
    feed(1);
    wait_done("t5", 10);

    // 6: async reset during FLUSH, then a clean frame
    start_frame(3);
    wait_pulses("t6_into_flush", 4);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_async_reset");
    #1 rst_n = 1'b1;
    repeat (2) cyc();
    start_frame(3);
    wait_pulses("t6_pulses", 6);
    chk("t6_rstlow", 64'(rstlow), 64'd2);
    feed(12);
    wait_done("t6", 20);
    chk("t6_errs", 64'({err_underrun, err_timeout}), 64'd0);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
